mtr_drv_ctrl: RTL and testbench
===============================

MTR_DRV_CTRL -- requirements
Module: mtr_drv_ctrl

Interface
REQ-001 Parameter SLEW, default 11'd16: maximum change of any duty output per PWM period.
REQ-002 Parameter DEAD_PRDS, default 4: number of whole PWM periods of zero duty enforced on a direction reversal (range 1..15).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  drive enable.
REQ-006 fault  input  1  overcurrent/fault indication, sampled synchronously.
REQ-007 clr_fault  input  1  fault clear request.
REQ-008 lft_cmd, rght_cmd  input  12 each  signed two's-complement drive commands.
REQ-009 lft_duty, rght_duty  output  11 each  duty values for the two 11-bit PWM generators.
REQ-010 lft_rev, rght_rev  output  1 each  direction outputs: 1 = reverse.
REQ-011 prd_strt  output  1  one-cycle pulse marking the start of each PWM period.
REQ-012 faulted  output  1  high while in FAULT.

Function
REQ-013 An 11-bit period counter cnt shall increment every clock and wrap from 2047 to 0; tick shall be defined as cnt==2047.
REQ-014 prd_strt shall be registered and high exactly during cycles with cnt==0 following a wrap, i.e. first 2048 cycles after reset release, then every 2048 cycles.
REQ-015 The duty and rev outputs shall be registered and shall change only on the tick edge, except for the forced-zero cases in REQ-022 and REQ-023.
REQ-016 Target magnitude shall be |cmd| saturated to 2047 (-2048 maps to 2047); target direction shall be cmd<0, and cmd==0 shall keep the current rev.
REQ-017 The top FSM shall have three states: IDLE, RUN and FAULT.
 - IDLE -> RUN on a tick with en=1; the first ramp step shall be applied on that same tick.
REQ-018 Each channel shall have a two-state FSM, CH_RUN and CH_DEAD, evaluated on each tick while the top FSM is in RUN.
REQ-019 CH_RUN behaviour, same direction:
 - duty moves toward the target magnitude by min(SLEW, |target - duty|);
 - no overshoot.
REQ-020 CH_RUN behaviour, direction differs:
 - if duty>0: duty = (duty>SLEW) ? duty-SLEW : 0, rev unchanged;
 - if duty==0: enter CH_DEAD, load the dead counter with DEAD_PRDS, duty held at 0.
REQ-021 CH_DEAD behaviour:
 - duty=0 and rev held; decrement the dead counter each tick;
 - on the tick where the counter reaches 0: rev = current target direction, return to CH_RUN, duty remains 0 for that period.
 - If the target has reverted to the old direction, rev stays unchanged; the dead time is still completed.
REQ-022 RUN -> IDLE on any clock edge where en=0:
 - both duties forced to 0 on that edge, without waiting for a tick;
 - channel FSMs forced to CH_RUN; rev held.
REQ-023 Entry to FAULT from any state on any clock edge where fault=1:
 - duties forced to 0 and channel FSMs forced to CH_RUN on that edge;
 - faulted=1 from the next cycle.
REQ-024 FAULT -> IDLE on a clock edge with clr_fault=1 and fault=0; faulted shall clear on that edge.
REQ-025 Priority, highest first: fault, then en=0, then tick processing; fault=1 with clr_fault=1 shall remain in FAULT.
REQ-026 Channels shall be independent; both shall update on the same tick.

Reset
REQ-027 While rst=1:
 - cnt=0, top FSM=IDLE, channels=CH_RUN, dead counters=0;
 - all duties=0, rev=0, prd_strt=0, faulted=0;
 - effect immediate, no clock edge required.
REQ-028 After rst deasserts, the period counter shall restart from 0, realigning prd_strt.

Verification
REQ-029 Ramp up: reset, en=1, lft_cmd=+100 -> lft_duty 16,32,48,64,80,96,100 at successive period starts; lft_rev=0; rght_duty=0.
REQ-030 Reversal: lft at duty 100 fwd, cmd=-50 ->
 - duty 84,68,52,36,20,4,0;
 - 4 periods of 0 (CH_DEAD), then lft_rev=1 with duty 0;
 - then 16,32,48,50.
REQ-031 Saturation: rght_cmd=-2048 -> target 2047, rev=1 after dead time, ramps to 2047 without overshoot; cmd=+2047 -> 2047.
REQ-032 Fault mid-ramp: fault=1 for one cycle at cnt=1000 ->
 - duties 0 next edge, faulted=1;
 - clr_fault=1 with fault=1 -> stays faulted;
 - clr_fault=1 with fault=0 -> faulted=0, IDLE;
 - en=1 -> ramp restarts from 16 at the next period start.
REQ-033 Disable: en dropped at cnt=500 with duty 500 -> duty 0 on the next edge, rev held; re-enable ramps from 0.
REQ-034 Async reset: rst pulsed mid-period between clock edges -> all outputs 0 immediately; first prd_strt 2048 cycles after release.

Source files
------------

// File: rtl/mtr_drv_ctrl.sv
// Dual-channel motor drive controller: PWM period counter, slew-limited duty
// ramps, dead-time enforced direction reversal and fault lockout.
module mtr_drv_ctrl #(
  parameter logic [10:0] SLEW      = 11'd16,
  parameter int unsigned DEAD_PRDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fault,
  input  logic               clr_fault,
  input  logic signed [11:0] lft_cmd,
  input  logic signed [11:0] rght_cmd,
  output logic        [10:0] lft_duty,
  output logic        [10:0] rght_duty,
  output logic               lft_rev,
  output logic               rght_rev,
  output logic               prd_strt,
  output logic               faulted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [0:0] CH_RUN  = 1'b0;
  localparam logic [0:0] CH_DEAD = 1'b1;

  localparam logic [3:0] DEAD_LD = 4'(DEAD_PRDS);

  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  logic        prd_q;
  logic [1:0]  st_q;
  logic [1:0]  st_d;
  logic [0:0]  ch_q   [2];
  logic [0:0]  ch_d   [2];
  logic [3:0]  dead_q [2];
  logic [3:0]  dead_d [2];
  logic [10:0] duty_q [2];
  logic [10:0] duty_d [2];
  logic        rev_q  [2];
  logic        rev_d  [2];

  logic signed [11:0] cmd [2];
  logic [11:0] neg  [2];
  logic [10:0] tmag [2];
  logic        tdir [2];
  logic        up   [2];
  logic [10:0] diff [2];
  logic [10:0] dlt  [2];
  logic        tick;
  logic        kill;
  logic        step;

  assign cmd[0] = lft_cmd;
  assign cmd[1] = rght_cmd;
  assign tick   = &cnt_q;
  assign cnt_d  = cnt_q + 11'd1;

  // -2048 negates to itself; its magnitude saturates to 2047
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      neg[i]  = 12'd0 - 12'(cmd[i]);
      tmag[i] = cmd[i][11] ? (neg[i][11] ? 11'h7FF : neg[i][10:0])
                           : cmd[i][10:0];
      tdir[i] = (cmd[i] == 12'sd0) ? rev_q[i] : cmd[i][11];
      up[i]   = tmag[i] > duty_q[i];
      diff[i] = up[i] ? (tmag[i] - duty_q[i]) : (duty_q[i] - tmag[i]);
      dlt[i]  = (diff[i] > SLEW) ? SLEW : diff[i];
    end
  end

  assign kill = fault | ((st_q != ST_FAULT) & ~en);
  assign step = ~kill & (st_q != ST_FAULT) & tick;

  always_comb begin
    st_d = st_q;
    if (fault) begin
      st_d = ST_FAULT;
    end else if (st_q == ST_FAULT) begin
      if (clr_fault) st_d = ST_IDLE;
    end else if (!en) begin
      st_d = ST_IDLE;
    end else if (tick) begin
      st_d = ST_RUN;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ch_d[i]   = ch_q[i];
      dead_d[i] = dead_q[i];
      duty_d[i] = duty_q[i];
      rev_d[i]  = rev_q[i];
      if (kill) begin
        ch_d[i]   = CH_RUN;
        dead_d[i] = 4'd0;
        duty_d[i] = 11'd0;
      end else if (step) begin
        if (ch_q[i] == CH_DEAD) begin
          duty_d[i] = 11'd0;
          dead_d[i] = dead_q[i] - 4'd1;
          if (dead_q[i] <= 4'd1) begin
            dead_d[i] = 4'd0;
            rev_d[i]  = tdir[i];
            ch_d[i]   = CH_RUN;
          end
        end else if (tdir[i] == rev_q[i]) begin
          duty_d[i] = up[i] ? (duty_q[i] + dlt[i]) : (duty_q[i] - dlt[i]);
        end else if (duty_q[i] != 11'd0) begin
          duty_d[i] = (duty_q[i] > SLEW) ? (duty_q[i] - SLEW) : 11'd0;
        end else begin
          ch_d[i]   = CH_DEAD;
          dead_d[i] = DEAD_LD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 11'd0;
      prd_q <= 1'b0;
      st_q  <= ST_IDLE;
      for (int i = 0; i < 2; i++) begin
        ch_q[i]   <= CH_RUN;
        dead_q[i] <= 4'd0;
        duty_q[i] <= 11'd0;
        rev_q[i]  <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_d;
      prd_q <= tick;
      st_q  <= st_d;
      for (int i = 0; i < 2; i++) begin
        ch_q[i]   <= ch_d[i];
        dead_q[i] <= dead_d[i];
        duty_q[i] <= duty_d[i];
        rev_q[i]  <= rev_d[i];
      end
    end
  end

  assign lft_duty  = duty_q[0];
  assign rght_duty = duty_q[1];
  assign lft_rev   = rev_q[0];
  assign rght_rev  = rev_q[1];
  assign prd_strt  = prd_q;
  assign faulted   = (st_q == ST_FAULT);

endmodule

// File: tb/tb_mtr_drv_ctrl.sv
// Bench for mtr_drv_ctrl: table of per-period expectations, directed corner
// sequences, and randomized stimulus against a cycle-level reference model.
module tb_mtr_drv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic fault = 1'b0;
  logic clr_fault = 1'b0;
  logic signed [11:0] lcmd [2];
  logic signed [11:0] rcmd [2];
  logic [10:0] ld [2];
  logic [10:0] rd [2];
  logic lr [2];
  logic rr [2];
  logic ps [2];
  logic flt [2];

  int nvec = 0;
  int nerr = 0;

  mtr_drv_ctrl u0 (
    .clk(clk), .rst(rst), .en(en), .fault(fault), .clr_fault(clr_fault),
    .lft_cmd(lcmd[0]), .rght_cmd(rcmd[0]),
    .lft_duty(ld[0]), .rght_duty(rd[0]),
    .lft_rev(lr[0]), .rght_rev(rr[0]),
    .prd_strt(ps[0]), .faulted(flt[0])
  );

  mtr_drv_ctrl #(.SLEW(11'd700), .DEAD_PRDS(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .fault(fault), .clr_fault(clr_fault),
    .lft_cmd(lcmd[1]), .rght_cmd(rcmd[1]),
    .lft_duty(ld[1]), .rght_duty(rd[1]),
    .lft_rev(lr[1]), .rght_rev(rr[1]),
    .prd_strt(ps[1]), .faulted(flt[1])
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  int m_since;
  int m_mode [2];
  int m_duty [2][2];
  bit m_rev  [2][2];
  int m_dead [2][2];

  function automatic int slew_of(input int k);
    return (k == 0) ? 16 : 700;
  endfunction

  function automatic int dead_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic model_reset();
    m_since = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE;
      for (int c = 0; c < 2; c++) begin
        m_duty[k][c] = 0;
        m_rev[k][c]  = 1'b0;
        m_dead[k][c] = 0;
      end
    end
  endtask

  task automatic ch_step(input int slew, input int dp, input int cmd,
                         inout int duty, inout bit rev, inout int dead);
    int mag;
    bit dir;
    mag = (cmd < 0) ? ((-cmd > 2047) ? 2047 : -cmd) : cmd;
    dir = (cmd == 0) ? rev : (cmd < 0);
    if (dead > 0) begin
      duty = 0;
      dead = dead - 1;
      if (dead == 0) rev = dir;
    end else if (dir == rev) begin
      if (duty < mag) duty = duty + ((mag - duty < slew) ? mag - duty : slew);
      else duty = duty - ((duty - mag < slew) ? duty - mag : slew);
    end else if (duty > 0) begin
      duty = (duty > slew) ? duty - slew : 0;
    end else begin
      dead = dp;
      duty = 0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    int cmd;
    int d;
    bit r;
    int dd;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_since % 2048) == 2047;
    m_since++;
    for (int k = 0; k < 2; k++) begin
      if (fault) begin
        m_mode[k] = M_FAULT;
        for (int c = 0; c < 2; c++) begin
          m_duty[k][c] = 0;
          m_dead[k][c] = 0;
        end
      end else if (m_mode[k] == M_FAULT) begin
        if (clr_fault) m_mode[k] = M_IDLE;
      end else if (!en) begin
        m_mode[k] = M_IDLE;
        for (int c = 0; c < 2; c++) begin
          m_duty[k][c] = 0;
          m_dead[k][c] = 0;
        end
      end else if (tick) begin
        m_mode[k] = M_RUN;
        for (int c = 0; c < 2; c++) begin
          cmd = (c == 0) ? int'(lcmd[k]) : int'(rcmd[k]);
          d = m_duty[k][c];
          r = m_rev[k][c];
          dd = m_dead[k][c];
          ch_step(slew_of(k), dead_of(k), cmd, d, r, dd);
          m_duty[k][c] = d;
          m_rev[k][c] = r;
          m_dead[k][c] = dd;
        end
      end
    end
  endtask

  function automatic logic [25:0] model_vec(input int k);
    logic prd;
    prd = (m_since > 0) && ((m_since % 2048) == 0);
    return {11'(m_duty[k][0]), m_rev[k][0], 11'(m_duty[k][1]), m_rev[k][1],
            prd, m_mode[k] == M_FAULT};
  endfunction

  function automatic logic [25:0] dut_vec(input int k);
    return {ld[k], lr[k], rd[k], rr[k], ps[k], flt[k]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("model_u%0d", k), 64'(dut_vec(k)), 64'(model_vec(k)));
  endtask

  task automatic wait_prd(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ps[0] && n < 2100);
    if (!ps[0]) begin
      nvec++;
      nerr++;
      $display("FAIL prd_timeout got=none exp=prd_strt within 2100 cycles");
    end
  endtask

  function automatic logic [47:0] both_vec();
    return {ld[0], lr[0], rd[0], rr[0], ld[1], lr[1], rd[1], rr[1]};
  endfunction

  // ---------------- per-period table ----------------
  typedef struct {
    logic en;
    logic signed [11:0] lc0, rc0, lc1, rc1;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input int lc0, input int rc0,
                              input int lc1, input int rc1,
                              input int l0, input int lr0,
                              input int r0, input int rr0,
                              input int l1, input int lr1,
                              input int r1, input int rr1);
    vec_t v;
    v.en = 1'b1;
    v.lc0 = 12'(lc0);
    v.rc0 = 12'(rc0);
    v.lc1 = 12'(lc1);
    v.rc1 = 12'(rc1);
    v.exp = {11'(l0), 1'(lr0), 11'(r0), 1'(rr0),
             11'(l1), 1'(lr1), 11'(r1), 1'(rr1)};
    return v;
  endfunction

  initial begin
    int n;
    int r;

    // u0: slew 16 ramp, reversal; u1: slew 700 saturation and reversal
    tbl[0]  = mk(100, -20, 2047, -2048,  16, 0,  0, 0,  700, 0,    0, 0);
    tbl[1]  = mk(100, -20, 2047, -2048,  32, 0,  0, 0, 1400, 0,    0, 0);
    tbl[2]  = mk(100, -20, 2047, -2048,  48, 0,  0, 0, 2047, 0,    0, 1);
    tbl[3]  = mk(100, -20, 2047, -2048,  64, 0,  0, 0, 2047, 0,  700, 1);
    tbl[4]  = mk(100, -20, 2047, -2048,  80, 0,  0, 1, 2047, 0, 1400, 1);
    tbl[5]  = mk(100, -20, 2047, -2048,  96, 0, 16, 1, 2047, 0, 2047, 1);
    tbl[6]  = mk(100, -20, 2047, -2048, 100, 0, 20, 1, 2047, 0, 2047, 1);
    tbl[7]  = mk(-50, -20, 2047,  2047,  84, 0, 20, 1, 2047, 0, 1347, 1);
    tbl[8]  = mk(-50, -20, 2047,  2047,  68, 0, 20, 1, 2047, 0,  647, 1);
    tbl[9]  = mk(-50, -20, 2047,  2047,  52, 0, 20, 1, 2047, 0,    0, 1);
    tbl[10] = mk(-50, -20, 2047,  2047,  36, 0, 20, 1, 2047, 0,    0, 1);
    tbl[11] = mk(-50, -20, 2047,  2047,  20, 0, 20, 1, 2047, 0,    0, 1);
    tbl[12] = mk(-50, -20, 2047,  2047,   4, 0, 20, 1, 2047, 0,    0, 0);
    tbl[13] = mk(-50, -20, 2047,  2047,   0, 0, 20, 1, 2047, 0,  700, 0);
    tbl[14] = mk(-50, -20, 2047,  2047,   0, 0, 20, 1, 2047, 0, 1400, 0);
    tbl[15] = mk(-50, -20, 2047,  2047,   0, 0, 20, 1, 2047, 0, 2047, 0);
    tbl[16] = mk(-50, -20, 2047,  2047,   0, 0, 20, 1, 2047, 0, 2047, 0);
    tbl[17] = mk(-50, -20, 2047,  2047,   0, 0, 20, 1, 2047, 0, 2047, 0);
    tbl[18] = mk(-50, -20, 2047,  2047,   0, 1, 20, 1, 2047, 0, 2047, 0);
    tbl[19] = mk(-50, -20, 2047,  2047,  16, 1, 20, 1, 2047, 0, 2047, 0);
    tbl[20] = mk(-50, -20, 2047,  2047,  32, 1, 20, 1, 2047, 0, 2047, 0);
    tbl[21] = mk(-50, -20, 2047,  2047,  48, 1, 20, 1, 2047, 0, 2047, 0);
    tbl[22] = mk(-50, -20, 2047,  2047,  50, 1, 20, 1, 2047, 0, 2047, 0);
    tbl[23] = mk(-50, -20, 2047,  2047,  50, 1, 20, 1, 2047, 0, 2047, 0);

    for (int k = 0; k < 2; k++) begin
      lcmd[k] = 12'sd0;
      rcmd[k] = 12'sd0;
    end

    // reset takes effect before any clock edge
    #1 rst = 1'b1;
    #2;
    check("reset", 64'({dut_vec(0), dut_vec(1)}), 64'd0);
    model_reset();
    #9 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      en = tbl[i].en;
      lcmd[0] = tbl[i].lc0;
      rcmd[0] = tbl[i].rc0;
      lcmd[1] = tbl[i].lc1;
      rcmd[1] = tbl[i].rc1;
      wait_prd(n);
      check($sformatf("row%0d", i), 64'(both_vec()), 64'(tbl[i].exp));
    end

    // disable mid-period: duties drop on the next edge, rev held
    repeat (500) cyc();
    en = 1'b0;
    cyc();
    check("disable", 64'(both_vec()),
          64'({11'd0, 1'b1, 11'd0, 1'b1, 11'd0, 1'b0, 11'd0, 1'b0}));
    repeat (10) cyc();
    en = 1'b1;
    wait_prd(n);
    check("reenable", 64'(both_vec()),
          64'({11'd16, 1'b1, 11'd16, 1'b1, 11'd700, 1'b0, 11'd700, 1'b0}));

    // one-cycle fault at cnt=1000
    repeat (1000) cyc();
    fault = 1'b1;
    cyc();
    fault = 1'b0;
    check("fault_edge",
          64'({ld[0], rd[0], ld[1], rd[1], flt[0], flt[1]}), 64'(2'b11));
    repeat (3) cyc();
    fault = 1'b1;
    clr_fault = 1'b1;
    cyc();
    check("clr_blocked", 64'({flt[0], flt[1]}), 64'(2'b11));
    fault = 1'b0;
    cyc();
    clr_fault = 1'b0;
    check("clr_ok", 64'({flt[0], flt[1]}), 64'(2'b00));
    wait_prd(n);
    check("restart", 64'(both_vec()),
          64'({11'd16, 1'b1, 11'd16, 1'b1, 11'd700, 1'b0, 11'd700, 1'b0}));

    // asynchronous reset pulse between edges
    repeat (300) cyc();
    #3 rst = 1'b1;
    #1;
    check("async_rst", 64'({dut_vec(0), dut_vec(1)}), 64'd0);
    model_reset();
    #2 rst = 1'b0;
    wait_prd(n);
    check("first_prd", 64'(n), 64'd2048);

    // randomized stimulus, checked every cycle by the model
    for (int c = 0; c < 4 * 2048; c++) begin
      r = int'($urandom_range(0, 9999));
      fault = (r < 4);
      clr_fault = ((r % 64) == 5);
      if (r >= 9990) en = ~en;
      if ((r % 512) == 7) begin
        lcmd[0] = 12'($urandom);
        rcmd[0] = 12'($urandom);
        lcmd[1] = 12'($urandom);
        rcmd[1] = 12'($urandom);
      end
      if ((r % 997) == 11) begin
        rcmd[0] = -12'sd2048;
        lcmd[1] = -12'sd2048;
      end
      if ((r % 1499) == 3) lcmd[0] = 12'sd0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
